// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg -- shared types and the immediate extension function for the
// decode-stage immediate generator.
//
// Contents:
//   IMM_SRC_W   width of the format select (3)
//   IMM_W_MAX   widest supported immediate (64); narrower builds truncate
//   imm_src_t   format select encoding (I, S, B, U, J, Z)
//   buf_state_t occupancy state of the 2-entry skid buffer
//   imm_ext_t   extension result: 64-bit immediate plus illegal-select flag
//   imm_extend  combinational extension of a 32-bit instruction
//
// Build option: define IMM_GEN_CSR_EN to decode select 101 as the Z-type
// CSR immediate; without it select 101 is treated as illegal.
package imm_gen_pkg;

    localparam int IMM_SRC_W = 3;
    localparam int IMM_W_MAX = 64;

    typedef enum logic [IMM_SRC_W-1:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100,
        IMM_Z = 3'b101
    } imm_src_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b01,
        BUF_FULL  = 2'b10
    } buf_state_t;

    typedef struct packed {
        logic [IMM_W_MAX-1:0] imm;
        logic                 err;
    } imm_ext_t;

    // The immediate is always built at 64 bits; sign extension is to the top
    // bit, so truncating to 32 bits gives the correct XLEN=32 result too.
    function automatic imm_ext_t imm_extend(input logic [31:0]          instr,
                                            input logic [IMM_SRC_W-1:0] src);
        imm_ext_t r;
        logic     s;
        s     = instr[31];
        r.imm = '0;
        r.err = 1'b0;
        case (src)
            IMM_I: r.imm = {{52{s}}, instr[31:20]};
            IMM_S: r.imm = {{52{s}}, instr[31:25], instr[11:7]};
            IMM_B: r.imm = {{52{s}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U: r.imm = {{32{s}}, instr[31:12], 12'b0};
            IMM_J: r.imm = {{44{s}}, instr[19:12], instr[20], instr[30:21], 1'b0};
`ifdef IMM_GEN_CSR_EN
            IMM_Z: r.imm = {{(IMM_W_MAX-5){1'b0}}, instr[19:15]};
`endif
            default: begin
                // Illegal select: zero immediate, flagged, beat still flows.
                r.imm = '0;
                r.err = 1'b1;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/imm_gen_pipe_skid.sv
// imm_skid_buf -- generic 2-entry valid/ready skid buffer.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst_n      synchronous active-low reset, discards buffered beats
//   flush      discard buffered beats; wins over same-cycle accept/consume
//   in_valid   / in_ready / in_data    upstream handshake (in_ready registered)
//   out_valid  / out_ready / out_data  downstream handshake (driven from M flops)
//
// Storage is a main register M (drives the outputs) and a skid register K
// that catches the one beat that can arrive while the consumer stalls.
// in_ready is registered from the next state, so out_ready never reaches
// in_ready combinationally.
module imm_skid_buf
    import imm_gen_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    buf_state_t   state_reg;
    buf_state_t   state_next;
    logic         in_ready_reg;
    logic [W-1:0] m_data_reg;
    logic [W-1:0] k_data_reg;

    logic accept;
    logic consume;
    logic load_m_in;
    logic load_m_k;
    logic load_k;

    // State register; in_ready follows the next state so it is a flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= BUF_EMPTY;
            in_ready_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            in_ready_reg <= (state_next != BUF_FULL);
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = BUF_EMPTY;
        end else begin
            case (state_reg)
                BUF_EMPTY: if (accept) state_next = BUF_ONE;
                BUF_ONE: begin
                    if (accept && !consume)      state_next = BUF_FULL;
                    else if (!accept && consume) state_next = BUF_EMPTY;
                end
                BUF_FULL:  if (consume) state_next = BUF_ONE;
                default:   state_next = BUF_EMPTY;
            endcase
        end
    end

    // Output / datapath-control logic.
    always_comb begin
        out_valid = (state_reg != BUF_EMPTY);
        accept    = in_valid && in_ready_reg;
        consume   = out_valid && out_ready;
        // A new beat goes straight to M when M is free or being emptied this
        // cycle; it parks in K only when M is occupied and stalled.
        load_m_in = !flush && accept &&
                    ((state_reg == BUF_EMPTY) || ((state_reg == BUF_ONE) && consume));
        load_m_k  = !flush && consume && (state_reg == BUF_FULL);
        load_k    = !flush && accept && (state_reg == BUF_ONE) && !consume;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_data_reg <= '0;
            k_data_reg <= '0;
        end else begin
            if (load_m_in) begin
                m_data_reg <= in_data;
            end else if (load_m_k) begin
                m_data_reg <= k_data_reg;
            end
            if (load_k) begin
                k_data_reg <= in_data;
            end
        end
    end

    assign in_ready = in_ready_reg;
    assign out_data = m_data_reg;

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe -- pipelined immediate generator for the decode stage.
//
// Parameters:
//   XLEN   immediate width, 32 or 64
//   TAG_W  sideband tag width (>= 1)
// Ports:
//   clk, rst_n (synchronous, active-low), flush (pipeline kill)
//   in_valid / in_ready      input handshake, in_ready registered
//   in_instr [31:0]          raw instruction
//   in_imm_src [2:0]         format select (I,S,B,U,J, Z when CSR build)
//   in_tag [TAG_W-1:0]       sideband returned unchanged
//   out_valid / out_ready    output handshake
//   out_imm [XLEN-1:0]       extended immediate
//   out_tag, out_err         beat tag and illegal-select flag
//
// Build option: IMM_GEN_CSR_EN enables the Z-type (CSR uimm) select.
//
// Extension is combinational on the input side; the result is captured in
// the skid buffer, so every output comes straight from a flop.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [IMM_SRC_W-1:0] in_imm_src,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_imm,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_err
);

    localparam int PAY_W = XLEN + TAG_W + 1;

    imm_ext_t         ext;
    logic [PAY_W-1:0] in_payload;
    logic [PAY_W-1:0] out_payload;

    always_comb begin
        ext = imm_extend(in_instr, in_imm_src);
    end

    assign in_payload = {ext.imm[XLEN-1:0], in_tag, ext.err};

    // Upper bits of the 64-bit result are pure sign copies for XLEN=32.
    generate
        if (XLEN < IMM_W_MAX) begin : g_trunc
            logic unused_hi;
            assign unused_hi = ^ext.imm[IMM_W_MAX-1:XLEN];
        end
    endgenerate

    imm_skid_buf #(
        .W (PAY_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_payload)
    );

    assign {out_imm, out_tag, out_err} = out_payload;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe -- directed self-checking bench for imm_gen_pipe.
// A 32-bit and a 64-bit instance share all stimulus; expected values are
// hand-computed constants.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [2:0]  in_imm_src;
    logic [7:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [7:0]  out_tag;
    logic        out_err;

    logic        in_ready64;
    logic        out_valid64;
    logic [63:0] out_imm64;
    logic [7:0]  out_tag64;
    logic        out_err64;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_imm_src (in_imm_src),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_imm    (out_imm),
        .out_tag    (out_tag),
        .out_err    (out_err)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready64),
        .in_instr   (in_instr),
        .in_imm_src (in_imm_src),
        .in_tag     (in_tag),
        .out_valid  (out_valid64),
        .out_ready  (out_ready),
        .out_imm    (out_imm64),
        .out_tag    (out_tag64),
        .out_err    (out_err64)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One beat into an empty pipe, check it one cycle later, then drain.
    task automatic single(input string name, input logic [31:0] instr, input logic [2:0] src,
                          input logic [7:0] tag, input logic [31:0] e32, input logic [63:0] e64,
                          input logic eerr);
        in_instr   = instr;
        in_imm_src = src;
        in_tag     = tag;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        step();
        in_valid = 1'b0;
        $display("txn %s: instr=%08h src=%0d tag=%02h -> valid=%0b imm=%08h imm64=%016h tag=%02h err=%0b",
                 name, instr, src, tag, out_valid, out_imm, out_imm64, out_tag, out_err);
        chk({name, "_valid"}, {63'd0, out_valid}, 64'd1);
        chk({name, "_imm"}, {32'd0, out_imm}, {32'd0, e32});
        chk({name, "_imm64"}, out_imm64, e64);
        chk({name, "_tag"}, {56'd0, out_tag}, {56'd0, tag});
        chk({name, "_err"}, {63'd0, out_err}, {63'd0, eerr});
        step();
        chk({name, "_drain"}, {63'd0, out_valid}, 64'd0);
    endtask

    // Two beats with the consumer stalled: leaves the buffer FULL.
    task automatic fill(input logic [7:0] a, input logic [7:0] b);
        out_ready  = 1'b0;
        in_instr   = 32'hFFF00093;
        in_imm_src = 3'b000;
        in_valid   = 1'b1;
        in_tag     = a;
        step();
        in_tag = b;
        step();
        in_valid = 1'b0;
        $display("txn fill: tags %02h,%02h in_ready=%0b", a, b, in_ready);
        chk("fill_in_ready", {63'd0, in_ready}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] z_e32;
        logic [63:0] z_e64;
        logic        z_err;
        int          cyc;
        int          rcv;
        logic [7:0]  exp_tag;
        logic        streaming;
        logic        acc;
        logic        cons;

        // Reset with in_valid high: it must be ignored.
        rst_n      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b1;
        in_instr   = 32'hFFF00093;
        in_imm_src = 3'b000;
        in_tag     = 8'hEE;
        out_ready  = 1'b0;
        step();
        step();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        $display("txn reset: valid=%0b ready=%0b imm=%08h tag=%02h err=%0b",
                 out_valid, in_ready, out_imm, out_tag, out_err);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_imm", {32'd0, out_imm}, 64'd0);
        chk("rst_out_tag", {56'd0, out_tag}, 64'd0);
        chk("rst_out_err", {63'd0, out_err}, 64'd0);

        // Formats.
        single("i_neg1", 32'hFFF00093, 3'b000, 8'h5A, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        single("s_neg4", 32'hFE112E23, 3'b001, 8'h11, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        single("b_neg4", 32'hFE000EE3, 3'b010, 8'h22, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        single("u_pos", 32'h123450B7, 3'b011, 8'h33, 32'h12345000, 64'h0000000012345000, 1'b0);
        single("u_neg", 32'h800000B7, 3'b011, 8'h44, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0);
        single("j_800", 32'h001000EF, 3'b100, 8'h55, 32'h00000800, 64'h0000000000000800, 1'b0);
        single("illegal7", 32'hFFF00093, 3'b111, 8'h66, 32'h0, 64'h0, 1'b1);
`ifdef IMM_GEN_CSR_EN
        z_e32 = 32'h5;
        z_e64 = 64'h5;
        z_err = 1'b0;
`else
        z_e32 = 32'h0;
        z_e64 = 64'h0;
        z_err = 1'b1;
`endif
        single("z_csr", 32'h0002D073, 3'b101, 8'h77, z_e32, z_e64, z_err);

        // Backpressure: tags 1..4 offered back to back, consumer stalled 3 cycles.
        in_instr   = 32'h123450B7;
        in_imm_src = 3'b011;
        in_valid   = 1'b1;
        in_tag     = 8'd1;
        exp_tag    = 8'd1;
        rcv        = 0;
        cyc        = 0;
        streaming  = 1'b0;
        while (rcv < 4 && cyc < 30) begin
            out_ready = (cyc >= 3);
            if (cyc == 2) begin
                chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
                chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
                chk("bp_hold_tag", {56'd0, out_tag}, 64'd1);
            end
            acc  = in_valid && in_ready;
            cons = out_valid && out_ready;
            if (cons) begin
                $display("txn bp: cycle %0d out_tag=%02h", cyc, out_tag);
                chk("bp_order", {56'd0, out_tag}, {56'd0, exp_tag});
                exp_tag++;
                rcv++;
                streaming = 1'b1;
            end else if (streaming) begin
                chk("bp_no_gap", {63'd0, out_valid}, 64'd1);
            end
            step();
            cyc++;
            if (acc) begin
                if (in_tag == 8'd4) in_valid = 1'b0;
                else in_tag++;
            end
        end
        chk("bp_received", rcv, 4);
        chk("bp_empty_after", {63'd0, out_valid}, 64'd0);

        // Flush while FULL with an input beat offered.
        fill(8'h11, 8'h12);
        in_valid = 1'b1;
        in_tag   = 8'h13;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        $display("txn flush_full: valid=%0b ready=%0b", out_valid, in_ready);
        chk("flush_full_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_full_ready", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flush_full_stay_empty", {63'd0, out_valid}, 64'd0);
        end

        // Flush while ONE, with a real same-cycle accept that must be dropped.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tag    = 8'h21;
        step();
        in_tag = 8'h22;
        flush  = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        $display("txn flush_one: valid=%0b ready=%0b", out_valid, in_ready);
        chk("flush_one_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_one_ready", {63'd0, in_ready}, 64'd1);
        step();
        chk("flush_one_dropped", {63'd0, out_valid}, 64'd0);
        single("post_flush", 32'h001000EF, 3'b100, 8'h23, 32'h00000800, 64'h0000000000000800, 1'b0);

        // Reset for one cycle while FULL.
        fill(8'h31, 8'h32);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_tag   = 8'h33;
        step();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        $display("txn rst_full: valid=%0b ready=%0b imm=%08h tag=%02h err=%0b",
                 out_valid, in_ready, out_imm, out_tag, out_err);
        chk("rst_full_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_full_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_full_imm", {32'd0, out_imm}, 64'd0);
        chk("rst_full_tag", {56'd0, out_tag}, 64'd0);
        chk("rst_full_err", {63'd0, out_err}, 64'd0);
        single("post_rst", 32'hFFF00093, 3'b000, 8'h34, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage. Accepts a 32-bit RISC-V instruction plus a format select. Produces the XLEN-wide extended immediate one cycle later behind a valid/ready handshake with a 2-entry skid buffer. Covers all base formats (I, S, B, U, J); the optional Z-type CSR immediate is compiled in separately. A sideband tag (PC, rd, etc.) travels with each result, and out-of-range selects are flagged instead of silently defaulting.

## Interface
Parameters:
- XLEN, 32, immediate output width; legal values 32 or 64.
- TAG_W, 8, width of pass-through sideband tag; must be ≥ 1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  discard all buffered results (pipeline kill).
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat; registered.
- in_instr  in  32  raw instruction word.
- in_imm_src  in  3  format select: 000 I, 001 S, 010 B, 011 U, 100 J, 101 Z (only when CSR feature enabled); all others illegal.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts result.
- out_imm  out  XLEN  extended immediate.
- out_tag  out  TAG_W  tag of the beat.
- out_err  out  1  illegal in_imm_src for this beat.

## Operation
- Accept on in_valid && in_ready; consume on out_valid && out_ready.
- Extension rules. s = instr[31], replicated to XLEN:
  - I: {s…, instr[31:20]}.
  - S: {s…, instr[31:25], instr[11:7]}.
  - B: {s…, instr[7], instr[30:25], instr[11:8], 0}.
  - U: {s…, instr[31:12], 12'b0}; for XLEN=64, bits 63:32 = s.
  - J: {s…, instr[19:12], instr[20], instr[30:21], 0}.
  - Z: zero-extend instr[19:15].
- Illegal select: out_imm = 0, out_err = 1; the beat still flows and the tag is preserved.
- Storage: main output register (M) plus skid register (K).
- State machine, three states:
  - EMPTY: M and K invalid.
  - ONE: M valid, K invalid.
  - FULL: M and K valid.
- Transitions:
  - EMPTY + accept → ONE.
  - ONE + accept, no consume → FULL (beat into K).
  - ONE + accept + consume → ONE (beat into M).
  - ONE + consume only → EMPTY.
  - FULL + consume → ONE (K moves to M).
  - In FULL, in_ready = 0, so there is no accept.
- Ordering is strictly FIFO; no beat is lost or duplicated.
- flush: next state EMPTY. Flush takes priority over a same-cycle accept (that beat is dropped) and over a consume. in_ready = 1 on the following cycle.
- Reset mid-operation: all buffered beats are discarded, identical to flush.

## Timing
- Latency: accept in cycle N → out_valid in cycle N+1 if M is free.
- Throughput: 1 beat/cycle while out_ready is held high.
- in_ready = (state != FULL), registered from next-state logic; no combinational path from out_ready to in_ready.
- out_* are driven directly from M flops; no combinational path from inputs to outputs.
- Reset values: out_valid 0, out_imm 0, out_tag 0, out_err 0, in_ready 1, state EMPTY.
- While rst_n = 0, in_valid is ignored.
- Holding rule: out_imm, out_tag and out_err stay stable while out_valid && !out_ready.

## Configuration
- IMM_GEN_CSR_EN defined: select 101 decodes Z-type (5-bit zero-extended uimm for CSRRxI).
- IMM_GEN_CSR_EN undefined: select 101 is illegal (out_imm 0, out_err 1). No zimm logic is present.

## Structure
- Shared package imm_gen_pkg holds:
  - enum imm_src_t (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z) at 3 bits.
  - constant IMM_SRC_W = 3.
  - pure function imm_extend(instr, src) returning XLEN bits plus err.
- One sub-module: imm_skid_buf, a generic 2-entry valid/ready skid buffer parametrised on payload width (XLEN + TAG_W + 1). The top holds only the extension function and the instantiation.

## Test plan
- I, XLEN=32: instr 0xFFF00093, src 000, tag 0x5A → next cycle out_imm 0xFFFFFFFF, out_tag 0x5A, out_err 0.
- B: instr 0xFE000EE3, src 010 → out_imm 0xFFFFFFFC. U: 0x123450B7, src 011 → 0x12345000. U with XLEN=64: 0x800000B7 → 0xFFFFFFFF80000000.
- Backpressure: in_valid high continuously with tags 1,2,3,4 and out_ready low for 3 cycles:
  - in_ready drops after tags 1,2 are accepted.
  - On release, tags emerge 1,2,3,4 in order, with no gaps once streaming.
- Flush in the same cycle as an accept while FULL → next cycle out_valid 0, in_ready 1; the dropped beat never appears.
- Illegal select 111 → out_err 1, out_imm 0. Select 101 with instr 0x0002D073:
  - out_imm 0x5 with IMM_GEN_CSR_EN defined.
  - out_err 1 without it.
- rst_n low for 1 cycle while FULL → all outputs return to reset values the next cycle; a subsequent beat has latency 1.
